cpu_fetch: RTL and testbench

Instruction-fetch stage of the RV32 pipeline, directly upstream of the decode stage. It owns the program counter and issues word requests to instruction memory over a valid/ready handshake. It holds returned instructions in a 2-entry in-order buffer and presents them, with their PC, to decode. Redirects from execute (branches, JAL, JALR) kill in-flight fetches and flush the buffer.

---
 rtl/cpu_fetch.sv | 150 +++++++++++++++
 tb/tb_cpu_fetch.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_fetch.sv
// Instruction-fetch stage: owns the PC, issues word requests to instruction
// memory, tracks outstanding requests in a 2-entry tag queue and hands
// returned instructions to decode through a 2-entry in-order buffer.
// Redirects from execute retarget the PC, kill in-flight fetches and flush
// the buffer. Total occupancy (outstanding + buffered) never exceeds two,
// so neither queue can overflow.
module cpu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc_out
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [31:0] pc_q, pc_d;

    logic [31:0] tag_pc_q   [2];
    logic [31:0] tag_pc_d   [2];
    logic        tag_kill_q [2];
    logic        tag_kill_d [2];
    logic [1:0]  outstanding_q, outstanding_d;

    logic [31:0] buf_pc_q  [2];
    logic [31:0] buf_pc_d  [2];
    logic [31:0] buf_ins_q [2];
    logic [31:0] buf_ins_d [2];
    logic [1:0]  count_q, count_d;

    logic        pop;
    logic        credit;
    logic        accept;
    logic        resp_take;
    logic        resp_keep;
    logic [2:0]  occupancy;

    // Target alignment forces the two low redirect bits to zero.
    logic        unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Handshake and credit: a slot is free once this cycle's pop is counted.
    always_comb begin
        pop            = (count_q != 2'd0) && !stall;
        occupancy      = {1'b0, outstanding_q} + {1'b0, count_q};
        credit         = (occupancy - {2'b00, pop}) < 3'd2;
        imem_req_valid = credit && !redirect_valid && !rst;
        accept         = imem_req_valid && imem_req_ready;
        resp_take      = imem_resp_valid && (outstanding_q != 2'd0);
        resp_keep      = resp_take && !tag_kill_q[0] && !redirect_valid;
    end

    // Next PC: sequential advance on accept, redirect target overrides.
    always_comb begin
        pc_d = pc_q;
        if (accept) begin
            pc_d = pc_q + 32'd4;
        end
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end
    end

    // Tag queue: response pops the head first, then an accept appends behind
    // whatever remains; a redirect marks every surviving entry as killed.
    always_comb begin
        tag_pc_d      = tag_pc_q;
        tag_kill_d    = tag_kill_q;
        outstanding_d = outstanding_q;
        if (resp_take) begin
            tag_pc_d[0]   = tag_pc_q[1];
            tag_kill_d[0] = tag_kill_q[1];
            outstanding_d = outstanding_q - 2'd1;
        end
        if (accept) begin
            tag_pc_d[outstanding_d[0]]   = pc_q;
            tag_kill_d[outstanding_d[0]] = 1'b0;
            outstanding_d                = outstanding_d + 2'd1;
        end
        if (redirect_valid) begin
            tag_kill_d[0] = 1'b1;
            tag_kill_d[1] = 1'b1;
        end
    end

    // Output buffer: decode pop shifts the head out before a live response
    // is appended; a redirect empties it regardless of the other two.
    always_comb begin
        buf_pc_d  = buf_pc_q;
        buf_ins_d = buf_ins_q;
        count_d   = count_q;
        if (pop) begin
            buf_pc_d[0]  = buf_pc_q[1];
            buf_ins_d[0] = buf_ins_q[1];
            count_d      = count_q - 2'd1;
        end
        if (resp_keep) begin
            buf_pc_d[count_d[0]]  = tag_pc_q[0];
            buf_ins_d[count_d[0]] = imem_resp_data;
            count_d               = count_d + 2'd1;
        end
        if (redirect_valid) begin
            count_d = 2'd0;
        end
    end

    // State registers; reset clears all bookkeeping so stale responses drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            outstanding_q <= 2'd0;
            count_q       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                tag_pc_q[i]   <= 32'd0;
                tag_kill_q[i] <= 1'b0;
                buf_pc_q[i]   <= 32'd0;
                buf_ins_q[i]  <= 32'd0;
            end
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            for (int i = 0; i < 2; i++) begin
                tag_pc_q[i]   <= tag_pc_d[i];
                tag_kill_q[i] <= tag_kill_d[i];
                buf_pc_q[i]   <= buf_pc_d[i];
                buf_ins_q[i]  <= buf_ins_d[i];
            end
        end
    end

    // Decode-facing outputs; a bubble presents a NOP at PC 0.
    always_comb begin
        imem_req_addr = pc_q;
        inst_valid    = (count_q != 2'd0);
        instruction   = inst_valid ? buf_ins_q[0] : NOP_INSTR;
        pc_out        = inst_valid ? buf_pc_q[0] : 32'd0;
    end

endmodule

// File: tb/tb_cpu_fetch.sv
// Bench for cpu_fetch: an in-order instruction memory with variable latency,
// a queue-based reference of what decode should see, directed scenarios with
// literal expectations, then a long randomized run.
module tb_cpu_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [31:0] pc_out;

    cpu_fetch #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .inst_valid     (inst_valid),
        .instruction    (instruction),
        .pc_out         (pc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    mreq_t mem_q[$];    // requests accepted by memory, not yet answered
    ent_t  m_buf[$];    // instructions decode must still receive, in order

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int epoch  = 0;
    logic [31:0] req_pc;   // next address fetch must request
    logic [31:0] exp_pc;   // next PC decode must see

    int   ready_pct = 100;
    int   stall_pct = 0;
    int   redir_pm  = 0;
    int   lat_lo    = 1;
    int   lat_hi    = 1;
    logic knob_rst  = 1'b1;
    logic force_redir = 1'b0;
    logic man_resp  = 1'b0;
    logic [31:0] force_target = 32'd0;

    logic        s_rst, s_rv, s_ready, s_resp_v, s_redir, s_stall, s_iv;
    logic [31:0] s_addr, s_rpc, s_pc, s_ins;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        mem_q.delete();
        m_buf.delete();
        epoch++;
        req_pc = RST_PC;
        exp_pc = RST_PC;
    endtask

    task automatic compare();
        logic exp_pop;
        logic exp_rv;
        exp_pop = (m_buf.size() > 0) && !stall;
        exp_rv  = !rst && !redirect_valid &&
                  ((mem_q.size() + m_buf.size() - (exp_pop ? 1 : 0)) < 2);
        chk("req_valid", imem_req_valid, exp_rv);
        chk("req_addr", imem_req_addr, req_pc);
        chk("inst_valid", inst_valid, m_buf.size() > 0);
        if (m_buf.size() > 0) begin
            chk("pc_out", pc_out, m_buf[0].pc);
            chk("instruction", instruction, m_buf[0].ins);
            chk("pc_sequence", pc_out, exp_pc);
        end else begin
            chk("bubble_instr", instruction, NOP);
            chk("bubble_pc", pc_out, 32'd0);
        end
    endtask

    task automatic update();
        mreq_t h;
        mreq_t n;
        ent_t  e;
        logic  keep;
        logic  pop;
        pop  = (m_buf.size() > 0) && !s_stall;
        keep = 1'b0;
        if (s_resp_v && mem_q.size() > 0) begin
            h = mem_q[0];
            mem_q.delete(0);
            keep = (h.epoch == epoch) && !s_redir;
        end
        if (s_rv && s_ready) begin
            n.addr  = req_pc;
            n.due   = cyc + $urandom_range(lat_hi, lat_lo);
            n.epoch = epoch;
            mem_q.push_back(n);
            req_pc = req_pc + 32'd4;
        end
        if (pop) begin
            m_buf.delete(0);
            exp_pc = exp_pc + 32'd4;
        end
        if (keep) begin
            e.pc  = h.addr;
            e.ins = memfn(h.addr);
            m_buf.push_back(e);
        end
        if (s_redir) begin
            epoch++;
            m_buf.delete();
            req_pc = {s_rpc[31:2], 2'b00};
            exp_pc = {s_rpc[31:2], 2'b00};
        end
    endtask

    task automatic step();
        rst            = knob_rst;
        imem_req_ready = ($urandom_range(99) < ready_pct);
        stall          = ($urandom_range(99) < stall_pct);
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_target;
        end else begin
            redirect_valid = ($urandom_range(999) < redir_pm);
            redirect_pc    = $urandom;
        end
        force_redir = 1'b0;
        if (man_resp) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = $urandom;
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memfn(mem_q[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        if (rst) model_reset();
        #1;
        compare();
        s_rst = rst; s_rv = imem_req_valid; s_ready = imem_req_ready;
        s_resp_v = imem_resp_valid; s_redir = redirect_valid; s_stall = stall;
        s_iv = inst_valid; s_addr = imem_req_addr; s_rpc = redirect_pc;
        s_pc = pc_out; s_ins = instruction;
        @(posedge clk);
        if (!s_rst) update();
        cyc++;
        #1;
    endtask

    initial begin
        int   acc;
        logic found;
        logic [31:0] held;

        // Reset and literal reset-state expectations.
        knob_rst = 1'b1;
        step();
        step();
        chk("rst_req_valid", s_rv, 1'b0);
        chk("rst_addr", s_addr, 32'h100);
        chk("rst_instr", s_ins, 32'h13);
        chk("rst_pc_out", s_pc, 32'h0);

        // Startup with 1-cycle memory: requests back to back, decode at cycle 2.
        knob_rst = 1'b0;
        step();
        chk("start_c0_valid", s_rv, 1'b1);
        chk("start_c0_addr", s_addr, 32'h100);
        step();
        chk("start_c1_addr", s_addr, 32'h104);
        chk("start_c1_iv", s_iv, 1'b0);
        step();
        chk("start_c2_iv", s_iv, 1'b1);
        chk("start_c2_pc", s_pc, 32'h100);
        step();
        chk("start_c3_pc", s_pc, 32'h104);
        for (int i = 0; i < 4; i++) step();

        // Stall for five cycles: bounded extra requests, output held.
        stall_pct = 100;
        acc = 0;
        step();
        held = s_pc;
        if (s_rv && s_ready) acc++;
        for (int i = 0; i < 4; i++) begin
            step();
            if (s_rv && s_ready) acc++;
            chk("stall_hold_pc", s_pc, held);
        end
        chk("stall_req_off", s_rv, 1'b0);
        chk("stall_extra_reqs_le2", acc <= 2, 1'b1);
        stall_pct = 0;
        for (int i = 0; i < 5; i++) step();

        // Redirect to 0x2002 with two requests outstanding.
        lat_lo = 4; lat_hi = 4;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_q.size() == 2) found = 1'b1;
            else step();
        end
        chk("redir_setup_2_outstanding", found, 1'b1);
        lat_lo = 1; lat_hi = 1;
        force_redir = 1'b1; force_target = 32'h2002;
        step();
        chk("redir_cycle_no_req", s_rv, 1'b0);
        step();
        chk("redir_next_addr", s_addr, 32'h2000);
        chk("redir_next_iv", s_iv, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (s_iv) found = 1'b1;
        end
        chk("redir_target_seen", found, 1'b1);
        chk("redir_first_pc", s_pc, 32'h2000);
        for (int i = 0; i < 4; i++) step();

        // Redirect coinciding with a response and a decode pop.
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (m_buf.size() > 0 && mem_q.size() > 0 && mem_q[0].due <= cyc) found = 1'b1;
            else step();
        end
        force_redir = 1'b1; force_target = 32'h3000;
        step();
        chk("triple_setup", {29'd0, s_resp_v, s_iv, s_stall}, 32'd6);
        step();
        chk("triple_buffer_empty", s_iv, 1'b0);
        for (int i = 0; i < 5; i++) step();

        // Memory not ready for three cycles: PC held, no skip afterwards.
        ready_pct = 0;
        step();
        held = s_addr;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("notready_addr_held", s_addr, held);
        end
        ready_pct = 100;
        step();
        chk("ready_resume_addr", s_addr, held);
        for (int i = 0; i < 5; i++) step();

        // PC wraps modulo 2^32.
        force_redir = 1'b1; force_target = 32'hFFFF_FFFD;
        step();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (s_iv) found = 1'b1;
        end
        chk("wrap_first_pc", s_pc, 32'hFFFF_FFFC);
        step();
        chk("wrap_second_pc", s_pc, 32'h0);
        for (int i = 0; i < 3; i++) step();

        // Reset with two outstanding, then two stale responses after release.
        lat_lo = 6; lat_hi = 6;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_q.size() == 2) found = 1'b1;
            else step();
        end
        chk("rst_setup_2_outstanding", found, 1'b1);
        lat_lo = 1; lat_hi = 1;
        ready_pct = 0;
        knob_rst = 1'b1;
        step();
        step();
        knob_rst = 1'b0;
        man_resp = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stale_no_iv", s_iv, 1'b0);
            chk("stale_addr", s_addr, 32'h100);
        end
        man_resp = 1'b0;
        step();
        chk("stale_after_iv", s_iv, 1'b0);
        ready_pct = 100;
        step();
        chk("restart_req_valid", s_rv, 1'b1);
        chk("restart_addr", s_addr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (s_iv) found = 1'b1;
        end
        chk("restart_first_pc", s_pc, 32'h100);

        // Randomized traffic with occasional resets.
        for (int blk = 0; blk < 20; blk++) begin
            ready_pct = $urandom_range(100, 30);
            stall_pct = $urandom_range(60, 0);
            redir_pm  = $urandom_range(80, 0);
            lat_lo    = 1;
            lat_hi    = $urandom_range(4, 1);
            if ($urandom_range(3) == 0) begin
                knob_rst = 1'b1;
                step();
                step();
                knob_rst = 1'b0;
            end
            for (int i = 0; i < 200; i++) step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
